// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: latches the EX bundle, runs one load/store on the
// valid/ack data port, aligns load data and hands {rf_we, wb_reg, wb_data} to WB.
module mem_stage #(
  parameter int EX_TO_MEM_W = 75,
  parameter int MEM_TO_WB_W = 38
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  input  logic                   ex_to_mem_valid,
  output logic                   mem_allow_in,
  output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
  output logic                   mem_to_wb_valid,
  input  logic                   wb_allow_in,
  output logic [39:0]            mem_to_id_bus,
  output logic                   data_req,
  output logic                   data_we,
  output logic [31:0]            data_addr,
  output logic [3:0]             data_wstrb,
  output logic [31:0]            data_wdata,
  input  logic                   data_ack,
  input  logic [31:0]            data_rdata,
  output logic                   mem_excp_valid,
  output logic [3:0]             mem_excp_code,
  output logic [31:0]            mem_excp_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state;
  logic                   mem_valid;
  logic [EX_TO_MEM_W-1:0] mem_regs;
  logic [31:0]            ldbuf;

  // Fields are taken from a zeroed copy while the stage is empty so nothing
  // un-reset ever reaches the outputs.
  logic [EX_TO_MEM_W-1:0] cur;
  logic        mem_re, mem_we, rf_we;
  logic [2:0]  funct3;
  logic [4:0]  wb_reg;
  logic [31:0] alu_result, store_data;

  assign cur = mem_valid ? mem_regs : '0;
  assign {mem_re, mem_we, funct3, rf_we, wb_reg, alu_result, store_data} = cur;

  logic is_mem, misaligned, ack_ok, ready_go, out_rf_we;
  logic [31:0] ld_word, bsel, ld_data, wb_data;
  logic [15:0] hsel;

  assign is_mem     = mem_re | mem_we;
  assign misaligned = is_mem & (((funct3[1:0] == 2'b01) & alu_result[0]) |
                                ((funct3[1:0] == 2'b10) & (|alu_result[1:0])));

  assign data_req = mem_valid & is_mem & ~misaligned & (state != DONE);
  assign ack_ok   = data_req & data_ack;
  assign ready_go = ~is_mem | misaligned | (state == DONE) | ack_ok;

  assign mem_to_wb_valid = mem_valid & ready_go;
  assign mem_allow_in    = ~mem_valid | (ready_go & wb_allow_in);

  // Request side
  assign data_we   = mem_we;
  assign data_addr = {alu_result[31:2], 2'b00};

  always_comb begin
    data_wstrb = 4'b1111;
    data_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        data_wstrb = 4'b0001 << alu_result[1:0];
        data_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        data_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment; ldbuf only holds meaningful data once DONE is reached
  always_comb begin
    ld_word = ack_ok ? data_rdata : ((state == DONE) ? ldbuf : 32'h0);
    bsel    = ld_word >> {alu_result[1:0], 3'b000};
    hsel    = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3[1:0])
      2'b00:   ld_data = funct3[2] ? {24'h0, bsel[7:0]} : {{24{bsel[7]}}, bsel[7:0]};
      2'b01:   ld_data = funct3[2] ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      default: ld_data = ld_word;
    endcase
  end

  assign wb_data   = mem_re ? ld_data : alu_result;
  assign out_rf_we = rf_we & ~mem_we & ~misaligned;

  assign mem_to_wb_bus = {out_rf_we, wb_reg, wb_data};
  assign mem_to_id_bus = {mem_valid, mem_valid & out_rf_we, mem_valid & mem_re & ~ready_go,
                          wb_reg, ready_go ? wb_data : alu_result};

  assign mem_excp_valid = mem_valid & misaligned;
  assign mem_excp_code  = mem_we ? 4'd6 : 4'd4;
  assign mem_excp_addr  = alu_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
    end else begin
      if (mem_allow_in) mem_valid <= ex_to_mem_valid;
      if (mem_allow_in && ex_to_mem_valid) mem_regs <= ex_to_mem_bus;
      case (state)
        IDLE, WAIT: begin
          if (ack_ok) begin
            ldbuf <= data_rdata;
            state <= wb_allow_in ? IDLE : DONE;
          end else if (data_req) begin
            state <= WAIT;
          end
        end
        DONE:    if (wb_allow_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the pipelined RV32I core, sitting between EX and WB.
- Latches the EX result bundle and performs the load/store access on a valid/ack data-memory port; variable latency, with ack allowed in the request cycle or any later cycle.
- Aligns and extends load data, then drives the 38-bit mem_to_wb_bus and mem_to_wb_valid toward the WB stage, which accepts on wb_allow_in.
- Also drives a forwarding bus to ID and flags misaligned accesses.

Parameters:
- EX_TO_MEM_W, 75, ex_to_mem_bus width: {mem_re, mem_we, funct3[2:0], rf_we, wb_reg[4:0], alu_result[31:0], store_data[31:0]}, MSB first.
- MEM_TO_WB_W, 38, mem_to_wb_bus width: {rf_we, wb_reg[4:0], wb_data[31:0]}.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- ex_to_mem_bus  in  75  EX result bundle
- ex_to_mem_valid  in  1  EX bundle valid
- mem_allow_in  out  1  stage can accept a new bundle this cycle
- mem_to_wb_bus  out  38  {rf_we, wb_reg, wb_data}
- mem_to_wb_valid  out  1  bundle on mem_to_wb_bus is complete
- wb_allow_in  in  1  WB accepts this cycle
- mem_to_id_bus  out  40  {mem_valid, rf_en, load_pending, wb_reg[4:0], alu_result/wb_data[31:0]}
- data_req  out  1  memory request, held until ack
- data_we  out  1  1 = store
- data_addr  out  32  {alu_result[31:2], 2'b00}
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-replicated store data
- data_ack  in  1  access complete; rdata valid this cycle
- data_rdata  in  32  load word
- mem_excp_valid  out  1  misaligned access held in stage
- mem_excp_code  out  4  4 = load misaligned, 6 = store misaligned
- mem_excp_addr  out  32  faulting alu_result

Behaviour:
- Input register: mem_regs <= ex_to_mem_bus when mem_allow_in && ex_to_mem_valid. mem_valid <= ex_to_mem_valid whenever mem_allow_in. Reset clears mem_valid only.
- is_mem = mem_re | mem_we.
- Misalignment:
  - LH/LHU/SH fault when addr[0]=1.
  - LW/SW fault when addr[1:0]≠0.
  - Byte accesses never fault.
  - On fault: no data_req; rf_we forced 0 on the output bus; mem_excp_* asserted combinationally while mem_valid; ready_go=1.
- FSM states IDLE, WAIT, DONE; reset → IDLE.
  - IDLE: data_req = mem_valid & is_mem & !misaligned.
    - req & ack → DONE.
    - req & !ack → WAIT.
  - WAIT: data_req=1, address/strb/wdata stable. ack → DONE.
  - DONE: data_req=0; load result in ldbuf (captured on the ack edge). On transfer (mem_to_wb_valid & wb_allow_in) → IDLE.
  - Transfer on the ack cycle when WB allows; ack in IDLE or WAIT with wb_allow_in=1 → IDLE directly.
- ready_go = !is_mem | misaligned | state==DONE | data_ack.
- mem_to_wb_valid = mem_valid & ready_go.
- mem_allow_in = !mem_valid | (ready_go & wb_allow_in).
- Never more than one outstanding request.
- Store encoding:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - SW: wstrb = 1111.
  - Stores never write the register file.
- Load extraction (word = data_ack ? data_rdata : ldbuf):
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: whole word.
- Non-memory ops: wb_data = alu_result.
- mem_to_id_bus:
  - rf_en = mem_valid & rf_we & !misaligned.
  - load_pending = mem_valid & mem_re & !ready_go.
  - data field = wb_data when ready_go, else alu_result.
- Back-pressure: while wb_allow_in=0 in DONE, outputs stay constant and data_req stays 0.
- Reset mid-access: FSM → IDLE, mem_valid=0, data_req drops next cycle; the memory discards the outstanding request.
- Reset output values: mem_to_wb_valid=0, mem_allow_in=1, data_req=0, mem_excp_valid=0. Bus fields are don't-care but must be X-free in simulation.

Test Plan:
- ALU op, rf_we=1, wb_reg=5, alu_result=0x1234, wb_allow_in=1 → next cycle mem_to_wb_valid=1, bus={1,5,0x00001234}, data_req=0.
- LB addr 0x1003, rdata=0x80FF_FF7F, ack 2 cycles after req → data_req high 3 cycles, load_pending=1 until ack, wb_data=0xFFFFFF80; with LBU, 0x00000080.
- SH addr 0x2002, store_data=0xABCD5678 → data_we=1, wstrb=1100, wdata=0x56785678, data_addr=0x2000, bus rf_we=0.
- LW addr 0x1001 → no data_req, mem_excp_valid=1, code=4, addr=0x1001, rf_we=0, mem_to_wb_valid=1 same cycle; SW addr 0x1002 → code=6.
- LW acked at once with rdata=0xDEADBEEF while wb_allow_in=0 for 3 cycles → DONE holds 0xDEADBEEF, mem_allow_in=0, single request; transfer on release, then a back-to-back load issues the next cycle.
- rst_n=0 during WAIT → next cycle data_req=0, mem_to_wb_valid=0, mem_allow_in=1, FSM IDLE.
